// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_sequencer_pkg                                     |
// | Description : Shared definitions for the program-counter           |
// |               sequencer: FSM state encoding, action decode and     |
// |               default stack depth.                                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package pc_sequencer_pkg;

  localparam int DEFAULT_STACK_DEPTH = 8;

  // Sequencer control states
  typedef enum logic [0:0] {
    PCS_RUN   = 1'b0,
    PCS_FAULT = 1'b1
  } pcs_state_t;

  // Next-PC source selected for an enabled RUN cycle
  typedef enum logic [1:0] {
    ACT_INC  = 2'd0,
    ACT_JMP  = 2'd1,
    ACT_CALL = 2'd2,
    ACT_RET  = 2'd3
  } pcs_action_t;

  // Resolve simultaneous strobes: RET > CALL > JMP/taken branch > increment
  function automatic pcs_action_t pick_action(input logic jmp,
                                              input logic branch_taken,
                                              input logic call,
                                              input logic ret);
    pcs_action_t act;
    if (ret)                      act = ACT_RET;
    else if (call)                act = ACT_CALL;
    else if (jmp || branch_taken) act = ACT_JMP;
    else                          act = ACT_INC;
    return act;
  endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_sequencer_return_stack                            |
// | Description : Return-address LIFO with a registered top-of-stack.  |
// |               No error handling: the caller never pushes when full |
// |               nor pops when empty, and never does both at once.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pc_sequencer_return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] below_idx;

  // Push writes the first free slot; after a pop the new top is the entry
  // two below the current count (count >= 2 whenever that value matters).
  assign wr_idx    = depth[PTR_W-1:0];
  assign below_idx = depth[PTR_W-1:0] - PTR_W'(2);
  assign full      = (depth == CNT_W'(DEPTH));
  assign empty     = (depth == '0);

  // Storage array: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Entry count and registered copy of the top entry
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      depth <= '0;
      top   <= '0;
    end else if (push) begin
      depth <= depth + CNT_W'(1);
      top   <= push_data;
    end else if (pop) begin
      depth <= depth - CNT_W'(1);
      top   <= mem[below_idx];
    end
  end

endmodule : pc_sequencer_return_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_sequencer                                         |
// | Description : Program-counter controller driving the instruction   |
// |               ROM address: linear fetch, JMP, taken branch,        |
// |               CALL/RET through a return stack, with sticky stack   |
// |               overflow/underflow detection and a FAULT freeze.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int ADDR_W      = 16,
  parameter int TGT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         jmp,
  input  logic                         branch_taken,
  input  logic                         call,
  input  logic                         ret,
  input  logic [TGT_W-1:0]             target,
  input  logic                         clear_fault,
  output logic [ADDR_W-1:0]            address,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         fault
);

  pcs_state_t        state;
  pcs_action_t       action;
  logic              advance;
  logic              stack_push;
  logic              stack_pop;
  logic              stack_clear;
  logic              stack_full;
  logic              stack_empty;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target_ext;

  assign action      = pick_action(jmp, branch_taken, call, ret);
  assign advance     = (state == PCS_RUN) && enable;
  assign pc_inc      = address + ADDR_W'(1);
  assign target_ext  = ADDR_W'(target);

  // The stack only moves on legal operations; illegal ones fault instead
  assign stack_push  = advance && (action == ACT_CALL) && !stack_full;
  assign stack_pop   = advance && (action == ACT_RET)  && !stack_empty;
  assign stack_clear = (state == PCS_FAULT) && clear_fault;

  pc_sequencer_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (stack_clear),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // FSM, PC register and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PCS_RUN;
      address   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      fault     <= 1'b0;
    end else begin
      unique case (state)
        PCS_RUN: begin
          if (enable) begin
            unique case (action)
              ACT_RET: begin
                if (stack_empty) begin
                  underflow <= 1'b1;
                  fault     <= 1'b1;
                  state     <= PCS_FAULT;
                end else begin
                  address <= stack_top;
                end
              end
              ACT_CALL: begin
                if (stack_full) begin
                  overflow <= 1'b1;
                  fault    <= 1'b1;
                  state    <= PCS_FAULT;
                end else begin
                  address <= target_ext;
                end
              end
              ACT_JMP: address <= target_ext;
              ACT_INC: address <= pc_inc;
              default: address <= pc_inc;
            endcase
          end
        end
        PCS_FAULT: begin
          // Frozen until cleared; enable is irrelevant here
          if (clear_fault) begin
            address   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            fault     <= 1'b0;
            state     <= PCS_RUN;
          end
        end
        default: state <= PCS_RUN;
      endcase
    end
  end

endmodule : pc_sequencer
`default_nettype wire
